// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit AXI-lite master.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } lsu_state_e;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Size 3 is never legal; halves and words must be naturally aligned.
  function automatic logic lsu_misaligned(input logic [1:0] addr, input logic [1:0] size);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr[0];
      SIZE_W:  bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store data/strobe shift-up and load data
// shift-down with sign or zero extension.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data
);

  logic [4:0]         shamt;
  logic [31:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign shamt   = {offset, 3'b000};
  assign shifted = bus_rdata >> shamt;
  assign byte_s  = shifted[7:0];
  assign half_s  = shifted[15:0];

  always_comb begin
    bus_wdata = store_data << shamt;
    case (size)
      SIZE_B:  bus_wstrb = STRB_B << offset;
      SIZE_H:  bus_wstrb = STRB_H << offset;
      SIZE_W:  bus_wstrb = STRB_W;
      default: bus_wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    load_data = shifted;
    case (size)
      SIZE_B:  load_data = is_unsigned ? {24'h0, shifted[7:0]}  : 32'(byte_s);
      SIZE_H:  load_data = is_unsigned ? {16'h0, shifted[15:0]} : 32'(half_s);
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_axi_lite.sv
// Load/store unit: one request at a time turned into an AXI-lite read or
// write, with a single registered response per request.
module lsu_axi_lite
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic                    bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
);

  lsu_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q, size_q;
  logic                  uns_q, we_q, err_q, aw_done, w_done, illegal;
  logic [31:0]           wdata_q, rdata_q, al_wdata, al_rdata;
  logic [3:0]            al_wstrb;

  assign illegal = lsu_misaligned(req_addr_i[1:0], req_size_i);

  lsu_data_align u_align (
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .store_data  (wdata_q),
    .bus_wdata   (al_wdata),
    .bus_wstrb   (al_wstrb),
    .bus_rdata   (rdata_i),
    .load_data   (al_rdata)
  );

  // Everything driven to the bus comes from latched request fields.
  assign araddr_o     = addr_q;
  assign awaddr_o     = addr_q;
  assign wdata_o      = al_wdata;
  assign wstrb_o      = we_q ? al_wstrb : 4'b0000;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    awvalid_o    = 1'b0;
    wvalid_o     = 1'b0;
    bready_o     = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = illegal ? RESP : (req_we_i ? WR_REQ : RD_ADDR);
      end
      RD_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) state_nxt = RESP;
      end
      WR_REQ: begin
        awvalid_o = !aw_done;
        wvalid_o  = !w_done;
        if ((aw_done || awready_i) && (w_done || wready_i)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          addr_q  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          off_q   <= req_addr_i[1:0];
          size_q  <= req_size_i;
          uns_q   <= req_unsigned_i;
          we_q    <= req_we_i;
          wdata_q <= req_wdata_i;
          rdata_q <= '0;
          err_q   <= illegal;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        RD_DATA: if (rvalid_i) begin
          rdata_q <= al_rdata;
          err_q   <= 1'b0;
        end
        WR_REQ: begin
          if (awvalid_o && awready_i) aw_done <= 1'b1;
          if (wvalid_o && wready_i)   w_done  <= 1'b1;
        end
        WR_RESP: if (bvalid_i) begin
          rdata_q <= '0;
          err_q   <= bresp_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_axi_lite.md
# lsu_axi_lite

Load/store unit bus master: accepts one load or store request at a time from the execute stage and converts it into AXI-lite read or write transactions toward the data-memory slave (`dram_axi_lite`-class). It handles byte/half/word sizing, write-strobe generation, read-data alignment and sign/zero extension, and misalignment detection. It returns one response per request over a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, bus data width; only 32 is supported.
- ADDR_WIDTH, 32, bus address width.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with valid
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  store data, right-justified
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err_o  out  1  misaligned, illegal size, or bresp error
- araddr_o / arvalid_o out, arready_i in  AXI-lite read address channel
- rdata_i / rvalid_i in, rready_o out  AXI-lite read data channel
- awaddr_o / awvalid_o out, awready_i in  AXI-lite write address channel
- wdata_o out 32, wstrb_o out 4, wvalid_o out 1, wready_i in 1  AXI-lite write data channel
- bresp_i in 1, bvalid_i in 1, bready_o out 1  write response channel; bresp_i = 1 means error

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: `req_ready_o` = 1. On fire, latch the request. Next state:
  - RESP with err = 1 if the request is illegal (see below);
  - otherwise RD_ADDR for a load or WR_REQ for a store.
- Illegal request: size 3; half with addr[0] = 1; word with addr[1:0] ≠ 0.
- Bus address is word-aligned: {addr[31:2], 2'b00}.
- RD_ADDR: `arvalid_o` = 1. On arready, go to RD_DATA.
- RD_DATA: `rready_o` = 1. On rvalid, capture the result and go to RESP.
  - Result: `(rdata_i >> 8*addr[1:0])` truncated to the size, then extended per `req_unsigned_i`.
  - Word loads are never extended.
- WR_REQ: `awvalid_o` and `wvalid_o` are asserted together.
  - Each channel drops independently after its own handshake; sticky flags aw_done and w_done track this.
  - Go to WR_RESP once both are done. Both may complete in the same cycle.
- Store data and strobes:
  - `wdata_o` = `req_wdata_i << 8*addr[1:0]`.
  - `wstrb_o` = base << addr[1:0], with base 4'b0001 for byte, 4'b0011 for half, 4'b1111 for word.
- WR_RESP: `bready_o` = 1. On bvalid, set err = `bresp_i`, rdata = 0, and go to RESP.
- RESP: `resp_valid_o` = 1, with rdata and err held stable. On resp_ready, go to IDLE.
- Once a valid is raised it is held until its handshake completes. Address, data and strobe are stable while valid is high.

## Timing
- Reset: state = IDLE.
  - `req_ready_o` = 1.
  - `arvalid_o`, `rready_o`, `awvalid_o`, `wvalid_o`, `bready_o`, `resp_valid_o` = 0.
  - `resp_rdata_o` = 0, `resp_err_o` = 0, `araddr_o`/`awaddr_o`/`wdata_o` = 0, `wstrb_o` = 0.
- All bus and response outputs are registered or decoded from the state register. There are no combinational paths from input to output.
- Request accepted at cycle T:
  - bus valid rises at T+1;
  - an illegal request gives `resp_valid_o` at T+1 with no bus activity.
- Load, zero-wait slave: arready at T+1, rvalid at T+2, `resp_valid_o` at T+3.
- Store, zero-wait slave: aw and w handshakes at T+1, bvalid at T+2, `resp_valid_o` at T+3.
- No new request is accepted until the response handshake completes, so at most one request is outstanding.
- Reset asserted mid-transaction returns the block to IDLE immediately and drops all valids. Partial handshakes are abandoned; the slave is reset by the same `rst_i`.

## Structure
- `lsu_pkg` holds:
  - `lsu_size_e` (SIZE_B, SIZE_H, SIZE_W);
  - `lsu_state_e`;
  - strobe base constants;
  - function `lsu_misaligned(addr, size)`.
- Sub-module `lsu_data_align` is purely combinational:
  - store path: wdata/wstrb shift;
  - load path: rdata shift and extension.
- The parent module keeps the FSM and registers.

## Test plan
- Load byte, signed: memory word 0x8899AABB at 0x80000000; lb @0x80000001 -> `araddr_o` 0x80000000, `resp_rdata_o` 0xFFFFFFAA, err 0.
- Load half, unsigned, slave with 10-cycle latency: lhu @0x80000002 -> 0x00008899. `arvalid_o` is held until arready, and `resp_valid_o` asserts the cycle after rvalid.
- Store byte: sb 0x000000CD @0x80000003 -> `awaddr_o` 0x80000000, `wdata_o` 0xCD000000, `wstrb_o` 4'b1000. Separately, sw 0x12345678 @0x80000004 -> `wstrb_o` 4'b1111.
- Skewed store handshakes: awready arrives 3 cycles before wready -> `awvalid_o` drops after its handshake, `wvalid_o` is held, and `bready_o` is raised only after both. A bresp_i = 1 gives `resp_err_o` = 1.
- Misaligned and illegal: lw @0x80000002, then size 3 -> no `arvalid_o`/`awvalid_o`, `resp_valid_o` at T+1 with err 1. With `resp_ready_i` = 0 for 5 cycles, the response is held stable and `req_ready_o` stays 0.
- Reset while in RD_DATA -> next cycle IDLE, `rready_o` = 0, `req_ready_o` = 1; a subsequent lw completes correctly.
